// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus target: block RAM, UART TX/RX FIFOs, cycle counter, stop flag
// Reads return registered data one edge after the address; IO window is addr[17:16]==2'b11.
module mem_io_responder #(
  parameter int RAM_AW      = 17,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_PTR_INC = {{TX_AW{1'b0}}, 1'b1};
  localparam logic [RX_AW:0] RX_PTR_INC = {{RX_AW{1'b0}}, 1'b1};
  localparam logic [TX_AW:0] TX_FULL_AT = (TX_AW+1)'(TX_DEPTH - FULL_MARGIN);

  localparam logic [15:0] OFF_UART = 16'h0000;
  localparam logic [15:0] OFF_CNT0 = 16'h0004;
  localparam logic [15:0] OFF_CNT1 = 16'h0005;
  localparam logic [15:0] OFF_CNT2 = 16'h0006;
  localparam logic [15:0] OFF_CNT3 = 16'h0007;

  logic              io_sel;
  logic              ram_rd;
  logic              ram_wr;
  logic              io_rd;
  logic              io_wr;
  logic [15:0]       io_off;
  logic [RAM_AW-1:0] ram_idx;
  logic              unused_addr_hi;

  assign io_sel         = (cpu_a[17:16] == 2'b11);
  assign io_off         = cpu_a[15:0];
  assign ram_idx        = cpu_a[RAM_AW-1:0];
  assign ram_rd         = rdy_in && !cpu_wr && !io_sel;
  assign ram_wr         = rdy_in &&  cpu_wr && !io_sel;
  assign io_rd          = rdy_in && !cpu_wr &&  io_sel;
  assign io_wr          = rdy_in &&  cpu_wr &&  io_sel;
  assign unused_addr_hi = ^cpu_a[31:18];

  // Block RAM kept free of reset so it maps onto RAM primitives.
  logic [7:0] ram [0:(2**RAM_AW)-1];
  logic [7:0] ram_q;

  always_ff @(posedge clk_in) begin
    if (ram_wr) ram[ram_idx] <= cpu_dout;
    if (ram_rd) ram_q <= ram[ram_idx];
  end

  logic [7:0]     tx_mem [0:TX_DEPTH-1];
  logic [TX_AW:0] tx_wr_ptr;
  logic [TX_AW:0] tx_rd_ptr;
  logic [TX_AW:0] tx_count;
  logic           tx_empty;
  logic           tx_full;
  logic           tx_pop;
  logic           tx_req;
  logic           tx_push;
  logic           tx_drop;
  logic [7:0]     tx_byte;

  assign tx_empty       = (tx_wr_ptr == tx_rd_ptr);
  assign tx_full        = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
                          (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
  assign tx_count       = tx_wr_ptr - tx_rd_ptr;
  assign tx_valid       = !tx_empty;
  assign tx_data        = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr[TX_AW-1:0]];
  assign tx_pop         = tx_valid && tx_ready;
  // A zero byte to the UART port is a no-op; the stop register queues a 0x00 terminator.
  assign tx_req         = io_wr && (((io_off == OFF_UART) && (cpu_dout != 8'h00)) ||
                                    (io_off == OFF_CNT0));
  assign tx_byte        = (io_off == OFF_CNT0) ? 8'h00 : cpu_dout;
  assign tx_push        = tx_req && (!tx_full || tx_pop);
  assign tx_drop        = tx_req && tx_full && !tx_pop;
  assign io_buffer_full = (tx_count >= TX_FULL_AT);

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= tx_byte;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PTR_INC;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PTR_INC;
    end
  end

  logic [7:0]     rx_mem [0:RX_DEPTH-1];
  logic [RX_AW:0] rx_wr_ptr;
  logic [RX_AW:0] rx_rd_ptr;
  logic           rx_empty;
  logic           rx_full;
  logic           rx_pop;
  logic           rx_push;
  logic [7:0]     rx_head;

  assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign rx_head  = rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign rx_pop   = io_rd && (io_off == OFF_UART) && !rx_empty;
  // The receiver strobe is independent of the CPU bus enable.
  assign rx_push  = rx_valid && (!rx_full || rx_pop);

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_PTR_INC;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_PTR_INC;
    end
  end

  logic [31:0] cycle_cnt;
  logic [31:8] snapshot;
  logic [7:0]  io_rd_data;
  logic [7:0]  io_q;
  logic        din_from_ram;

  always_comb begin
    io_rd_data = 8'h00;
    case (io_off)
      OFF_UART: io_rd_data = rx_empty ? 8'h00 : rx_head;
      OFF_CNT0: io_rd_data = cycle_cnt[7:0];
      OFF_CNT1: io_rd_data = snapshot[15:8];
      OFF_CNT2: io_rd_data = snapshot[23:16];
      OFF_CNT3: io_rd_data = snapshot[31:24];
      default:  io_rd_data = 8'h00;
    endcase
  end

  // Only the upper three snapshot bytes are ever read back; byte 0 comes live from the counter.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cycle_cnt    <= '0;
      snapshot     <= '0;
      io_q         <= 8'h00;
      din_from_ram <= 1'b0;
      program_stop <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (ram_rd) begin
        din_from_ram <= 1'b1;
      end else if (io_rd) begin
        din_from_ram <= 1'b0;
        io_q         <= io_rd_data;
      end
      if (io_rd && (io_off == OFF_CNT0)) snapshot <= cycle_cnt[31:8];
      if (io_wr && (io_off == OFF_CNT0)) program_stop <= 1'b1;
      if (tx_drop) tx_overflow <= 1'b1;
    end
  end

  assign cpu_din = din_from_ram ? ram_q : io_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - scoreboard bench for mem_io_responder
// Directed scenarios then random bus traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_mem_io_responder;

  localparam int DEPTH  = 16;
  localparam int MARGIN = 2;

  logic        clk_in   = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        rdy_in   = 1'b0;
  logic [31:0] cpu_a    = '0;
  logic [7:0]  cpu_dout = '0;
  logic        cpu_wr   = 1'b0;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data  = '0;
  logic        rx_valid = 1'b0;
  logic        program_stop;
  logic        tx_overflow;

  mem_io_responder dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .cpu_a(cpu_a),
    .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_din(cpu_din),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .program_stop(program_stop), .tx_overflow(tx_overflow)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  logic [7:0]  m_tx [$];
  logic [7:0]  m_rx [$];
  logic [7:0]  m_ram [int];
  logic        m_stop = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [31:0] m_snap = '0;
  logic [31:0] edges  = '0;

  logic [8:0]  sb_rd [$];
  logic [7:0]  sb_tx [$];
  logic        rd_issue = 1'b0;
  logic        rd_due   = 1'b0;
  logic        mon_en   = 1'b0;

  // Rising edges seen since reset was released: the expected cycle counter.
  always @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) edges <= '0;
    else           edges <= edges + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_in) rd_due <= rd_issue && mon_en;

  always @(negedge clk_in) begin
    logic [8:0] e;
    if (mon_en) begin
      if (rd_due) begin
        if (sb_rd.size() == 0) check("rd_scoreboard_empty", 1, 0);
        else begin
          e = sb_rd.pop_front();
          if (e[8]) check("cpu_din", cpu_din, e[7:0]);
        end
      end
      if (tx_valid && tx_ready) begin
        if (sb_tx.size() == 0) check("tx_unexpected_byte", tx_data, 32'h1ff);
        else check("tx_data", tx_data, sb_tx.pop_front());
      end
      check("tx_valid", tx_valid, m_tx.size() != 0);
      check("io_buffer_full", io_buffer_full, (DEPTH - m_tx.size()) <= MARGIN);
      check("program_stop", program_stop, m_stop);
      check("tx_overflow", tx_overflow, m_ovf);
    end
  end

  // One bus cycle: drive inputs, predict from the model, then advance the model past the edge.
  task automatic bus(input logic rdy, input logic [31:0] a, input logic wr, input logic [7:0] d,
                     input logic txr, input logic rxv, input logic [7:0] rxd);
    logic io, tx_pop, rx_pop, tx_req, tx_acc, rx_acc;
    logic [15:0] off;
    logic [7:0] tx_byte;
    logic [8:0] exp;
    int idx;
    rdy_in = rdy; cpu_a = a; cpu_wr = wr; cpu_dout = d;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    io  = (a[17:16] == 2'b11);
    off = a[15:0];
    idx = int'(a[16:0]);
    tx_pop = txr && (m_tx.size() != 0);
    rx_pop = rdy && io && !wr && (off == 16'h0) && (m_rx.size() != 0);
    rd_issue = rdy && !wr;
    exp = 9'h000;
    if (rdy && !wr) begin
      if (!io) exp = m_ram.exists(idx) ? {1'b1, m_ram[idx]} : 9'h000;
      else begin
        case (off)
          16'h0: exp = {1'b1, (m_rx.size() != 0) ? m_rx[0] : 8'h00};
          16'h4: begin exp = {1'b1, edges[7:0]}; m_snap = edges; end
          16'h5: exp = {1'b1, m_snap[15:8]};
          16'h6: exp = {1'b1, m_snap[23:16]};
          16'h7: exp = {1'b1, m_snap[31:24]};
          default: exp = 9'h100;
        endcase
      end
      sb_rd.push_back(exp);
    end
    tx_req  = rdy && io && wr && (((off == 16'h0) && (d != 8'h00)) || (off == 16'h4));
    tx_byte = (off == 16'h4) ? 8'h00 : d;
    tx_acc  = tx_req && ((m_tx.size() < DEPTH) || tx_pop);
    rx_acc  = rxv && ((m_rx.size() < DEPTH) || rx_pop);
    @(posedge clk_in); #2;
    if (tx_pop) void'(m_tx.pop_front());
    if (rx_pop) void'(m_rx.pop_front());
    if (tx_acc) begin m_tx.push_back(tx_byte); sb_tx.push_back(tx_byte); end
    else if (tx_req) m_ovf = 1'b1;
    if (rx_acc) m_rx.push_back(rxd);
    if (rdy && io && wr && (off == 16'h4)) m_stop = 1'b1;
    if (rdy && !io && wr) m_ram[idx] = d;
  endtask

  task automatic idle(input logic txr);
    bus(1'b0, 32'h0, 1'b0, 8'h00, txr, 1'b0, 8'h00);
  endtask

  // Assert reset between clock edges and confirm the outputs clear without an edge.
  task automatic do_reset();
    mon_en = 1'b0; rd_issue = 1'b0;
    rdy_in = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
    rst_n_in = 1'b0;
    #1;
    check("rst_cpu_din", cpu_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_io_buffer_full", io_buffer_full, 1'b0);
    check("rst_program_stop", program_stop, 1'b0);
    check("rst_tx_overflow", tx_overflow, 1'b0);
    m_tx.delete(); m_rx.delete(); sb_rd.delete(); sb_tx.delete();
    m_stop = 1'b0; m_ovf = 1'b0; m_snap = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in); rst_n_in = 1'b1;
    @(posedge clk_in); #2;
    mon_en = 1'b1;
  endtask

  int ram_set [8] = '{0, 16, 1234, 4099, 65535, 65536, 131071, 32'h0002_0005};

  initial begin
    #3;
    do_reset();

    bus(1, 32'h0000_0010, 1, 8'hA5, 0, 0, 0);
    bus(1, 32'h0000_0010, 0, 8'h00, 0, 0, 0);
    idle(0);

    bus(1, 32'h0003_0000, 1, 8'h48, 1, 0, 0);
    bus(1, 32'h0003_0000, 1, 8'h69, 1, 0, 0);
    bus(1, 32'h0003_0000, 1, 8'h00, 1, 0, 0);
    repeat (4) idle(1);

    for (int k = 0; k < 17; k++) bus(1, 32'h0003_0000, 1, 8'(k + 1), 0, 0, 0);
    repeat (20) idle(1);

    do_reset();
    repeat (100) idle(0);
    for (int k = 4; k < 8; k++) bus(1, 32'h0003_0000 + 32'(k), 0, 8'h00, 0, 0, 0);
    repeat (3) idle(0);
    for (int k = 5; k < 8; k++) bus(1, 32'h0003_0000 + 32'(k), 0, 8'h00, 0, 0, 0);

    bus(0, 32'h0, 0, 8'h00, 0, 1, 8'h41);
    bus(1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
    bus(1, 32'h0003_0000, 0, 8'h00, 0, 0, 0);
    idle(0);

    bus(1, 32'h0003_0000, 1, 8'h41, 0, 0, 0);
    bus(1, 32'h0003_0000, 1, 8'h42, 0, 0, 0);
    bus(1, 32'h0003_0004, 1, 8'h99, 0, 0, 0);
    idle(1);
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      int op;
      logic [31:0] a;
      logic [7:0] d;
      logic w, rdy, txr;
      op = $urandom_range(0, 9);
      d  = 8'($urandom);
      w  = 1'b0;
      a  = 32'h0;
      case (op)
        0, 1: begin a = 32'(ram_set[$urandom_range(0, 7)]); w = (op == 0); end
        2, 3: begin
          a = 32'h0003_0000; w = 1'b1;
          if ($urandom_range(0, 7) == 0) d = 8'h00;
        end
        4: a = 32'h0003_0000;
        5: a = 32'h0003_0004 + 32'($urandom_range(0, 3));
        6: begin a = 32'h0003_0000 + 32'($urandom_range(1, 15)); w = $urandom_range(0, 1) == 1; end
        7: begin a = 32'h0003_0004; w = ($urandom_range(0, 19) == 0); end
        default: a = 32'h0;
      endcase
      a   = a | {14'($urandom), 18'd0};
      rdy = ($urandom_range(0, 99) < 85);
      txr = (((i / 250) % 2) == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 1) == 1);
      bus(rdy, a, w, d, txr, $urandom_range(0, 3) == 0, 8'($urandom));
    end

    for (int k = 0; k < 64 && m_tx.size() != 0; k++) idle(1);
    idle(1);
    @(negedge clk_in); #1;
    check("tx_scoreboard_drained", sb_tx.size(), 0);
    check("rd_scoreboard_drained", sb_rd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
